dmem_lsu: RTL

- Load/store unit on the CPU side that acts as the initiator driving the word-addressed data memory (is_load / is_store / mem_addr / store_data / load_data).
- Accepts RV32I load/store requests from the execute stage and converts byte addresses to word indices.
- Extracts and sign- or zero-extends sub-word load data.
- Performs read-modify-write for SB/SH, because the data memory has no byte enables.
- Flags misaligned and unsupported accesses without touching memory.

---
 rtl/dmem_lsu.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32I load/store unit driving a word-addressed data memory, with sub-word extraction, RMW for SB/SH and fault detection
module dmem_lsu #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_illegal,
    output logic        is_load,
    output logic        is_store,
    output logic [31:0] mem_addr,
    output logic [31:0] store_data,
    input  logic [31:0] load_data
);
    localparam int AW = ADDR_WIDTH + 2;
    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;
    state_t      state_q, state_d;
    logic        st_q, st_d, mis_q, mis_d, ill_q, ill_d;
    logic [2:0]  f3_q, f3_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, word_q, word_d, rdata_q, rdata_d;
    logic [31:0] merged, ext;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic        illegal, misaligned, unused_addr;
    assign unused_addr = ^req_addr[31:AW];
    assign illegal    = req_store ? (req_funct3 >= 3'd3) : (req_funct3 == 3'd3 || req_funct3 >= 3'd6);
    assign misaligned = (req_funct3[1:0] == 2'd1 && req_addr[0]) || (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
    assign ld_b = load_data[{addr_q[1:0], 3'b000} +: 8];
    assign ld_h = load_data[{addr_q[1], 4'b0000} +: 16];
    assign ext  = f3_q[1:0] == 2'd0 ? {{24{~f3_q[2] & ld_b[7]}}, ld_b} :
                  f3_q[1:0] == 2'd1 ? {{16{~f3_q[2] & ld_h[15]}}, ld_h} : load_data;
    always_comb begin
        merged = word_q;
        if (f3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
    assign req_ready       = state_q == IDLE;
    assign resp_valid      = state_q == RESP;
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = mis_q;
    assign resp_illegal    = ill_q;
    assign is_load         = state_q == LOAD || state_q == RMW_RD;
    assign is_store        = state_q == STORE || state_q == RMW_WR;
    assign mem_addr        = {{(32 - ADDR_WIDTH){1'b0}}, addr_q[AW-1:2]};
    assign store_data      = state_q == STORE ? wdata_q : state_q == RMW_WR ? merged : 32'd0;
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE: if (req_valid) begin
                st_d    = req_store;
                f3_d    = req_funct3;
                addr_d  = req_addr[AW-1:0];
                wdata_d = req_wdata;
                if (illegal || misaligned) begin
                    rdata_d = 32'd0;
                    ill_d   = illegal;
                    mis_d   = !illegal;
                    state_d = RESP;
                end else begin
                    state_d = !req_store ? LOAD : req_funct3 == 3'd2 ? STORE : RMW_RD;
                end
            end
            LOAD: begin
                rdata_d = ext;
                mis_d   = 1'b0;
                ill_d   = 1'b0;
                state_d = RESP;
            end
            RMW_RD: begin
                word_d  = load_data;
                state_d = RMW_WR;
            end
            STORE, RMW_WR: begin
                rdata_d = 32'd0;
                mis_d   = 1'b0;
                ill_d   = 1'b0;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            st_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            word_q  <= 32'd0;
            rdata_q <= 32'd0;
            mis_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            ill_q   <= ill_d;
        end
    end
endmodule
